// File: rtl/stream_pkg.sv
// ============================================================================
// stream_pkg: shared types and helpers for the stream_downsizer block.
// Rev 1.0
// ============================================================================
`default_nettype none

package stream_pkg;

   typedef enum logic [0:0] {
      DS_IDLE  = 1'b0,
      DS_SHIFT = 1'b1
   } ds_state_t;

   function automatic int ratio_of(input int in_w, input int out_w);
      return in_w / out_w;
   endfunction

   // A zero or oversized lane count means "whole word".
   function automatic int clamp_len(input int len, input int ratio);
      return ((len == 0) || (len > ratio)) ? ratio : len;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ds_word_fifo.sv
// ============================================================================
// ds_word_fifo: synchronous word FIFO with combinational read port.
// Rev 1.0
// ============================================================================
`default_nettype none

module ds_word_fifo #(
   parameter int W     = 35,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [W-1:0]  wdata,
   input  logic          push,
   input  logic          pop,
   output logic [W-1:0]  rdata,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Power-of-two depth lets the pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/stream_downsizer.sv
// ============================================================================
// stream_downsizer: buffers wide words and emits them as narrow lanes.
// Optional status ports under STREAM_DOWNSIZER_STATUS_EN. Rev 1.0
// ============================================================================
`default_nettype none

module stream_downsizer
   import stream_pkg::*;
#(
   parameter int IN_W      = 32,
   parameter int OUT_W     = 8,
   parameter int DEPTH     = 4,
   parameter int MSB_FIRST = 0,
   localparam int RATIO    = ratio_of(IN_W, OUT_W),
   localparam int LEN_W    = $clog2(RATIO) + 1,
   localparam int CNT_W    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IN_W-1:0]  in_data,
   input  logic [LEN_W-1:0] in_len,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_last,
   output logic             out_valid,
   input  logic             out_ready
`ifdef STREAM_DOWNSIZER_STATUS_EN
   ,
   output logic [CNT_W-1:0] fifo_level,
   output logic             ovf_sticky
`endif
);

   localparam int FW = IN_W + LEN_W;

   logic [FW-1:0]    fifo_wdata;
   logic [FW-1:0]    fifo_rdata;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   logic             push;
   logic             load;
   ds_state_t        state;
   ds_state_t        state_nx;
   logic [IN_W-1:0]  shreg;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] lane_cnt;
   logic             lane_hs;
   logic             last_lane;

   assign in_ready   = !fifo_full;
   assign push       = in_valid && in_ready;
   assign fifo_wdata = {LEN_W'(clamp_len(int'(in_len), RATIO)), in_data};

   ds_word_fifo #(
      .W     (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .wdata (fifo_wdata),
      .push  (push),
      .pop   (load),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign out_valid = (state == DS_SHIFT);
   assign last_lane = (lane_cnt == len_q - LEN_W'(1));
   assign out_last  = out_valid && last_lane;
   assign lane_hs   = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) state <= DS_IDLE;
      else     state <= state_nx;
   end

   // Reloading on the last-lane handshake keeps words back-to-back.
   always_comb begin
      state_nx = state;
      load     = 1'b0;
      case (state)
         DS_IDLE: begin
            if (!fifo_empty) begin
               load     = 1'b1;
               state_nx = DS_SHIFT;
            end
         end
         DS_SHIFT: begin
            if (lane_hs && last_lane) begin
               if (!fifo_empty) load = 1'b1;
               else             state_nx = DS_IDLE;
            end
         end
         default: state_nx = DS_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shreg    <= '0;
         len_q    <= '0;
         lane_cnt <= '0;
      end else if (load) begin
         shreg    <= fifo_rdata[IN_W-1:0];
         len_q    <= fifo_rdata[FW-1:IN_W];
         lane_cnt <= '0;
      end else if (lane_hs) begin
         lane_cnt <= lane_cnt + LEN_W'(1);
         if (MSB_FIRST != 0) shreg <= shreg << OUT_W;
         else                shreg <= shreg >> OUT_W;
      end
   end

   generate
      if (MSB_FIRST != 0) begin : g_msb_first
         assign out_data = shreg[IN_W-1 -: OUT_W];
      end else begin : g_lsb_first
         assign out_data = shreg[OUT_W-1:0];
      end
   endgenerate

`ifdef STREAM_DOWNSIZER_STATUS_EN
   assign fifo_level = fifo_count;

   always_ff @(posedge clk) begin
      if (rst)                       ovf_sticky <= 1'b0;
      else if (in_valid && !in_ready) ovf_sticky <= 1'b1;
   end
`else
   logic unused_count;
   assign unused_count = ^fifo_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stream_downsizer.sv
// ============================================================================
// tb_stream_downsizer: LSB-first and MSB-first instances against a queue model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_stream_downsizer;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst;
   logic [31:0] in_data;
   logic [2:0]  in_len;
   logic        in_valid;
   logic        out_ready;

   logic        in_ready_l, in_ready_m;
   logic [7:0]  od_l, od_m;
   logic        ol_l, ol_m;
   logic        ov_l, ov_m;
`ifdef STREAM_DOWNSIZER_STATUS_EN
   logic [2:0]  lvl_l, lvl_m;
   logic        ovf_l, ovf_m;
`endif

   stream_downsizer #(.IN_W(32), .OUT_W(8), .DEPTH(DEPTH), .MSB_FIRST(0)) u_lsb (
      .clk(clk), .rst(rst), .in_data(in_data), .in_len(in_len),
      .in_valid(in_valid), .in_ready(in_ready_l), .out_data(od_l),
      .out_last(ol_l), .out_valid(ov_l), .out_ready(out_ready)
`ifdef STREAM_DOWNSIZER_STATUS_EN
      , .fifo_level(lvl_l), .ovf_sticky(ovf_l)
`endif
   );

   stream_downsizer #(.IN_W(32), .OUT_W(8), .DEPTH(DEPTH), .MSB_FIRST(1)) u_msb (
      .clk(clk), .rst(rst), .in_data(in_data), .in_len(in_len),
      .in_valid(in_valid), .in_ready(in_ready_m), .out_data(od_m),
      .out_last(ol_m), .out_valid(ov_m), .out_ready(out_ready)
`ifdef STREAM_DOWNSIZER_STATUS_EN
      , .fifo_level(lvl_m), .ovf_sticky(ovf_m)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: queue of accepted words plus the word being emitted.
   logic [31:0] q_data[$];
   int          q_len[$];
   logic [31:0] cur = '0;
   int          cur_len = 0;
   int          lane = 0;
   bit          busy = 1'b0;
   bit          ovf_exp = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] lane_lsb(input logic [31:0] w, input int i);
      return 8'(w >> (8 * i));
   endfunction

   function automatic logic [7:0] lane_msb(input logic [31:0] w, input int i);
      return 8'(w >> (8 * (3 - i)));
   endfunction

   task automatic model_step();
      bit full_m;
      bit hs;
      bit last;
      bit pop_m;
      full_m = (q_data.size() >= DEPTH);
      hs     = busy && out_ready;
      last   = hs && (lane == cur_len - 1);
      pop_m  = (!busy || last) && (q_data.size() > 0);
      if (rst) begin
         q_data.delete();
         q_len.delete();
         busy    = 1'b0;
         lane    = 0;
         ovf_exp = 1'b0;
         return;
      end
      if (in_valid && full_m) ovf_exp = 1'b1;
      if (hs)   lane++;
      if (last) busy = 1'b0;
      if (pop_m) begin
         cur     = q_data.pop_front();
         cur_len = q_len.pop_front();
         lane    = 0;
         busy    = 1'b1;
      end
      if (in_valid && !full_m) begin
         q_data.push_back(in_data);
         q_len.push_back((in_len == 0 || in_len > 4) ? 4 : int'(in_len));
      end
   endtask

   // Called at a falling edge with inputs already driven: check, clock, model.
   task automatic tick();
      int  n;
      bit  last_exp;
      n        = q_data.size();
      last_exp = busy && (lane == cur_len - 1);
      check_val("in_ready_lsb", in_ready_l, n < DEPTH);
      check_val("in_ready_msb", in_ready_m, n < DEPTH);
      check_val("out_valid_lsb", ov_l, busy);
      check_val("out_valid_msb", ov_m, busy);
      check_val("out_last_lsb", ol_l, last_exp);
      check_val("out_last_msb", ol_m, last_exp);
      if (busy) begin
         check_val("lane_lsb", od_l, lane_lsb(cur, lane));
         check_val("lane_msb", od_m, lane_msb(cur, lane));
      end
`ifdef STREAM_DOWNSIZER_STATUS_EN
      check_val("fifo_level", lvl_l, n);
      check_val("ovf_sticky", ovf_l, ovf_exp);
      check_val("ovf_sticky_msb", ovf_m, ovf_exp);
`endif
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic drive(input bit v, input logic [31:0] d, input logic [2:0] l, input bit r);
      in_valid  = v;
      in_data   = d;
      in_len    = l;
      out_ready = r;
      tick();
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_len = '0; out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      tick();
      rst = 1'b0;
      check_val("rst_out_data_lsb", od_l, 8'h00);
      check_val("rst_out_data_msb", od_m, 8'h00);
      check_val("rst_in_ready", in_ready_l, 1'b1);
      check_val("rst_out_valid", ov_l, 1'b0);

      // Single full word, then idle long enough to drain.
      drive(1, 32'h12345678, 3'd4, 1);
      repeat (6) drive(0, 32'h0, 3'd0, 1);

      // Two words back-to-back: eight lanes with no gap.
      drive(1, 32'h00001234, 3'd4, 1);
      drive(1, 32'h00005678, 3'd4, 1);
      repeat (10) drive(0, 32'h0, 3'd0, 1);

      // Partial word then a zero-length (full) word.
      drive(1, 32'hAABBCCDD, 3'd2, 1);
      drive(1, 32'h11223344, 3'd0, 1);
      drive(1, 32'h55667788, 3'd7, 1);
      repeat (12) drive(0, 32'h0, 3'd0, 1);

      // Back-pressure: fill FIFO and serializer, overflow attempt, then drain.
      for (int i = 0; i < 8; i++) drive(1, 32'hC0DE0000 + i, 3'd4, 0);
      repeat (3) drive(0, 32'h0, 3'd0, 0);
      repeat (30) drive(0, 32'h0, 3'd0, 1);

      // Reset mid-word after two lanes, with more words queued.
      drive(1, 32'hDEADBEEF, 3'd4, 1);
      drive(1, 32'hFEEDFACE, 3'd4, 1);
      drive(0, 32'h0, 3'd0, 1);
      drive(0, 32'h0, 3'd0, 1);
      rst = 1'b1;
      drive(1, 32'h0BADF00D, 3'd4, 1);
      rst = 1'b0;
      check_val("midrst_out_valid", ov_l, 1'b0);
      repeat (4) drive(0, 32'h0, 3'd0, 1);

      // Randomized traffic with occasional resets.
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 299) == 0);
         drive(($urandom_range(0, 99) < 55), $urandom(), 3'($urandom_range(0, 7)),
               ($urandom_range(0, 99) < 70));
      end
      rst = 1'b0;
      repeat (30) drive(0, 32'h0, 3'd0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
